pipe_hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage pipelined CPU, alongside the EX-stage forwarding logic. Detects load-use hazards, taken branches resolved in MEM, and multi-cycle MULT/DIV instructions occupying EX. Drives per-stage write enables and flushes accordingly. Keeps saturating stall and flush counters for performance debug.

---
 rtl/pipe_hazard_ctrl.sv | 125 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, taken-branch flushes and
// multi-cycle MULT/DIV occupancy of EX, plus saturating stall/flush counters.
//
// state   | meaning
// --------+------------------------------------------------------------
// RUN     | normal issue; br > md > lu hazard priority evaluated
// MD_BUSY | MULT/DIV holds EX; md_cnt_q counts the remaining EX cycles
module pipe_hazard_ctrl #(
    parameter int unsigned MD_LAT = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [4:0]  ID_Rs,
    input  logic [4:0]  ID_Rt,
    input  logic        ID_uses_Rt,
    input  logic        ID_EX_MemRead,
    input  logic [4:0]  ID_EX_Rt,
    input  logic        ID_EX_md,
    input  logic        EX_MEM_Branch_taken,
    output logic        PC_Write_o,
    output logic        IF_ID_Write_o,
    output logic        ID_EX_Write_o,
    output logic        IF_ID_Flush_o,
    output logic        ID_EX_Flush_o,
    output logic        EX_MEM_Flush_o,
    output logic        md_start_o,
    output logic        md_busy_o,
    output logic [15:0] stall_cnt_o,
    output logic [15:0] flush_cnt_o
);

    typedef enum logic {RUN = 1'b0, MD_BUSY = 1'b1} state_t;

    localparam logic [3:0] MD_LOAD = 4'(MD_LAT - 1);

    state_t      state_q, state_d;
    logic [3:0]  md_cnt_q, md_cnt_d;
    logic [15:0] stall_cnt_q, flush_cnt_q;

    logic lu, br, md;
    logic pc_w, ifid_w, idex_w, ifid_f, idex_f, exmem_f, start;
    logic flush_evt;

    assign lu = ID_EX_MemRead && (ID_EX_Rt != 5'd0) &&
                ((ID_EX_Rt == ID_Rs) || (ID_uses_Rt && (ID_EX_Rt == ID_Rt)));
    assign br = EX_MEM_Branch_taken;
    assign md = ID_EX_md;

    always_comb begin
        pc_w      = 1'b1;
        ifid_w    = 1'b1;
        idex_w    = 1'b1;
        ifid_f    = 1'b0;
        idex_f    = 1'b0;
        exmem_f   = 1'b0;
        start     = 1'b0;
        flush_evt = 1'b0;
        state_d   = state_q;
        md_cnt_d  = md_cnt_q;
        case (state_q)
            RUN: begin
                if (br) begin
                    ifid_f    = 1'b1;
                    idex_f    = 1'b1;
                    exmem_f   = 1'b1;
                    flush_evt = 1'b1;
                end else if (md) begin
                    start    = 1'b1;
                    pc_w     = 1'b0;
                    ifid_w   = 1'b0;
                    idex_w   = 1'b0;
                    exmem_f  = 1'b1;
                    md_cnt_d = MD_LOAD;
                    state_d  = MD_BUSY;
                end else if (lu) begin
                    pc_w   = 1'b0;
                    ifid_w = 1'b0;
                    idex_f = 1'b1;
                end
            end
            MD_BUSY: begin
                md_cnt_d = md_cnt_q - 4'd1;
                if (md_cnt_q > 4'd1) begin
                    pc_w    = 1'b0;
                    ifid_w  = 1'b0;
                    idex_w  = 1'b0;
                    exmem_f = 1'b1;
                end else begin
                    // Last EX cycle: defaults let EX/MEM capture the result.
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // While reset is asserted the pipeline sees plain defaults whatever the inputs.
    assign PC_Write_o     = rst_i ? pc_w    : 1'b1;
    assign IF_ID_Write_o  = rst_i ? ifid_w  : 1'b1;
    assign ID_EX_Write_o  = rst_i ? idex_w  : 1'b1;
    assign IF_ID_Flush_o  = rst_i & ifid_f;
    assign ID_EX_Flush_o  = rst_i & idex_f;
    assign EX_MEM_Flush_o = rst_i & exmem_f;
    assign md_start_o     = rst_i & start;
    assign md_busy_o      = rst_i & (state_q == MD_BUSY);
    assign stall_cnt_o    = stall_cnt_q;
    assign flush_cnt_o    = flush_cnt_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= RUN;
            md_cnt_q    <= 4'd0;
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            state_q  <= state_d;
            md_cnt_q <= md_cnt_d;
            if (!pc_w && (stall_cnt_q != 16'hFFFF))
                stall_cnt_q <= stall_cnt_q + 16'd1;
            if (flush_evt && (flush_cnt_q != 16'hFFFF))
                flush_cnt_q <= flush_cnt_q + 16'd1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (MD_LAT=4): a vector table for the
// single-cycle hazards plus hand-written MULT/DIV, reset and saturation sequences.
module tb_pipe_hazard_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [4:0]  ID_Rs, ID_Rt, ID_EX_Rt;
    logic        ID_uses_Rt, ID_EX_MemRead, ID_EX_md, EX_MEM_Branch_taken;
    logic        PC_Write_o, IF_ID_Write_o, ID_EX_Write_o;
    logic        IF_ID_Flush_o, ID_EX_Flush_o, EX_MEM_Flush_o;
    logic        md_start_o, md_busy_o;
    logic [15:0] stall_cnt_o, flush_cnt_o;

    int n_cmp = 0;
    int n_err = 0;

    // {PC_W, IFID_W, IDEX_W, IFID_F, IDEX_F, EXMEM_F, START, BUSY}
    localparam logic [7:0] IDLE = 8'b111_000_00;
    localparam logic [7:0] LU   = 8'b001_010_00;
    localparam logic [7:0] BR   = 8'b111_111_00;
    localparam logic [7:0] MDS  = 8'b000_001_10;
    localparam logic [7:0] MDB  = 8'b000_001_01;
    localparam logic [7:0] MDL  = 8'b111_000_01;

    pipe_hazard_ctrl #(.MD_LAT(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_uses_Rt(ID_uses_Rt),
        .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_Rt(ID_EX_Rt), .ID_EX_md(ID_EX_md),
        .EX_MEM_Branch_taken(EX_MEM_Branch_taken),
        .PC_Write_o(PC_Write_o), .IF_ID_Write_o(IF_ID_Write_o), .ID_EX_Write_o(ID_EX_Write_o),
        .IF_ID_Flush_o(IF_ID_Flush_o), .ID_EX_Flush_o(ID_EX_Flush_o),
        .EX_MEM_Flush_o(EX_MEM_Flush_o), .md_start_o(md_start_o), .md_busy_o(md_busy_o),
        .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        uses;
        logic        memrd;
        logic [4:0]  exrt;
        logic        md;
        logic        br;
        logic [7:0]  exp;
        logic [15:0] es;
        logic [15:0] ef;
    } vec_t;

    vec_t tbl[10];

    task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                          input logic memrd, input logic [4:0] exrt, input logic md,
                          input logic br);
        ID_Rs = rs; ID_Rt = rt; ID_uses_Rt = uses; ID_EX_MemRead = memrd;
        ID_EX_Rt = exrt; ID_EX_md = md; EX_MEM_Branch_taken = br;
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic cmp(input string name, input logic [7:0] exp,
                       input logic [15:0] es, input logic [15:0] ef);
        logic [7:0] act;
        act = {PC_Write_o, IF_ID_Write_o, ID_EX_Write_o, IF_ID_Flush_o,
               ID_EX_Flush_o, EX_MEM_Flush_o, md_start_o, md_busy_o};
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s ctrl: got %b want %b", name, act, exp);
        end
        n_cmp++;
        if (stall_cnt_o !== es) begin
            n_err++;
            $display("FAIL %s stall_cnt: got %0d want %0d", name, stall_cnt_o, es);
        end
        n_cmp++;
        if (flush_cnt_o !== ef) begin
            n_err++;
            $display("FAIL %s flush_cnt: got %0d want %0d", name, flush_cnt_o, ef);
        end
    endtask

    task automatic chk(input string name, input logic [7:0] exp,
                       input logic [15:0] es, input logic [15:0] ef);
        @(negedge clk_i);
        cmp(name, exp, es, ef);
    endtask

    initial begin
        //            rs  rt  use mr  exrt md  br  exp   stall flush
        tbl[0] = '{5'd0, 5'd0, 0, 0, 5'd0, 0, 0, IDLE, 16'd0, 16'd0};
        tbl[1] = '{5'd8, 5'd0, 0, 1, 5'd8, 0, 0, LU,   16'd0, 16'd0};
        tbl[2] = '{5'd0, 5'd0, 0, 0, 5'd0, 0, 0, IDLE, 16'd1, 16'd0};
        tbl[3] = '{5'd0, 5'd0, 0, 1, 5'd0, 0, 0, IDLE, 16'd1, 16'd0};
        tbl[4] = '{5'd3, 5'd9, 0, 1, 5'd9, 0, 0, IDLE, 16'd1, 16'd0};
        tbl[5] = '{5'd3, 5'd9, 1, 1, 5'd9, 0, 0, LU,   16'd1, 16'd0};
        tbl[6] = '{5'd7, 5'd0, 0, 1, 5'd8, 0, 0, IDLE, 16'd2, 16'd0};
        tbl[7] = '{5'd8, 5'd0, 0, 0, 5'd8, 0, 0, IDLE, 16'd2, 16'd0};
        tbl[8] = '{5'd8, 5'd0, 0, 1, 5'd8, 1, 1, BR,   16'd2, 16'd0};
        tbl[9] = '{5'd0, 5'd0, 0, 0, 5'd0, 0, 0, IDLE, 16'd2, 16'd1};

        // Reset with every hazard present: outputs must stay at defaults.
        rst_i = 1'b0;
        set_in(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b1);
        chk("reset", IDLE, 16'd0, 16'd0);
        rst_i = 1'b1;
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);

        for (int i = 0; i < 10; i++) begin
            step();
            set_in(tbl[i].rs, tbl[i].rt, tbl[i].uses, tbl[i].memrd,
                   tbl[i].exrt, tbl[i].md, tbl[i].br);
            chk($sformatf("vec%0d", i), tbl[i].exp, tbl[i].es, tbl[i].ef);
        end

        // MULT/DIV with lu alongside, br/lu ignored while busy, then back-to-back.
        step(); set_in(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0); chk("md_t0", MDS, 16'd2, 16'd1);
        step(); set_in(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b1); chk("md_t1", MDB, 16'd3, 16'd1);
        step(); chk("md_t2", MDB, 16'd4, 16'd1);
        step(); chk("md_t3", MDL, 16'd5, 16'd1);
        step(); set_in(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0); chk("md2_t0", MDS, 16'd5, 16'd1);
        step(); set_in(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b1); chk("md2_t1", MDB, 16'd6, 16'd1);
        step(); chk("md2_t2", MDB, 16'd7, 16'd1);
        step(); chk("md2_t3", MDL, 16'd8, 16'd1);
        step(); set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0); chk("md_done", IDLE, 16'd8, 16'd1);

        // Reset landing in the second MD_BUSY cycle aborts the sequence.
        step(); set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0); chk("rmd_t0", MDS, 16'd8, 16'd1);
        step(); chk("rmd_t1", MDB, 16'd9, 16'd1);
        step();
        #1 rst_i = 1'b0;
        #1 cmp("rmd_reset", IDLE, 16'd0, 16'd0);
        @(negedge clk_i);
        rst_i = 1'b1;
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        chk("rmd_release", IDLE, 16'd0, 16'd0);
        step(); set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0); chk("rmd_restart", MDS, 16'd0, 16'd0);
        step(); set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0); chk("rmd_b1", MDB, 16'd1, 16'd0);
        step(); chk("rmd_b2", MDB, 16'd2, 16'd0);
        step(); chk("rmd_last", MDL, 16'd3, 16'd0);
        step(); chk("rmd_run", IDLE, 16'd3, 16'd0);

        // Hold a load-use hazard long enough to saturate the stall counter.
        step(); set_in(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0);
        repeat (65540) @(posedge clk_i);
        chk("sat", LU, 16'hFFFF, 16'd0);
        chk("sat_hold", LU, 16'hFFFF, 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
